// File: rtl/tensor_slice_pkg.sv
// rtl/tensor_slice_pkg.sv - shared types and default widths for the tensor-slice chain wrapper
package tensor_slice_pkg;
    localparam int A_W_DEF = 64;
    localparam int B_W_DEF = 64;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_e;
    typedef enum logic [1:0] {OP_PASS, OP_XOR, OP_ADD, OP_MAX} op_e;
endpackage

// File: rtl/tensor_slice_chain_wrapper_if.sv
// rtl/tensor_slice_chain_wrapper_if.sv - ap_ctrl_chain control, operand stream and result bundle
interface tensor_slice_chain_wrapper_if
    import tensor_slice_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
);
    logic               ap_ce;
    logic               ap_start;
    logic               ap_continue;
    logic               ap_idle;
    logic               ap_ready;
    logic               ap_done;
    logic [1:0]         op;
    logic               in_valid;
    logic               in_ready;
    logic [A_W-1:0]     a_data;
    logic [B_W-1:0]     b_data;
    logic [A_W+B_W-1:0] c_data_out;
    logic               c_data_available_port;

    modport master (
        output ap_ce, ap_start, ap_continue, op, in_valid, a_data, b_data,
        input  ap_idle, ap_ready, ap_done, in_ready, c_data_out, c_data_available_port
    );

    modport slave (
        input  ap_ce, ap_start, ap_continue, op, in_valid, a_data, b_data,
        output ap_idle, ap_ready, ap_done, in_ready, c_data_out, c_data_available_port
    );
endinterface

// File: rtl/tensor_slice_reduce.sv
// rtl/tensor_slice_reduce.sv - one reduction lane: folds accepted beats into an accumulator
module tensor_slice_reduce
    import tensor_slice_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  op_e          op,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic [W-1:0] acc_nxt
);
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] step;

    always_comb begin
        case (op)
            OP_PASS: step = din;
            OP_XOR:  step = acc_q ^ din;
            OP_ADD:  step = acc_q + din;
            default: step = (din > acc_q) ? din : acc_q;
        endcase
    end

    // Clear wins over en; the caller gates both with the clock enable.
    assign acc_d = clear ? '0 : (en ? step : acc_q);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc     = acc_q;
    assign acc_nxt = acc_d;
endmodule

// File: rtl/tensor_slice_chain_wrapper.sv
// rtl/tensor_slice_chain_wrapper.sv - multi-beat ap_ctrl_chain black-box wrapper with fixed latency
module tensor_slice_chain_wrapper
    import tensor_slice_pkg::*;
#(
    parameter int A_W     = A_W_DEF,
    parameter int B_W     = B_W_DEF,
    parameter int BEATS   = 8,
    parameter int LATENCY = 4
) (
    input logic                         ap_clk,
    input logic                         ap_rst_n,
    tensor_slice_chain_wrapper_if.slave bus
);
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [A_W+B_W-1:0] c_data_q, c_data_d;
    logic               avail_q, avail_d;
    logic               accept;
    logic               last_beat;
    logic               start_take;
    logic [A_W-1:0]     a_acc, a_nxt;
    logic [B_W-1:0]     b_acc, b_nxt;

    assign accept     = (state_q == LOAD) && bus.in_valid;
    assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
    assign start_take = (state_q == IDLE) && bus.ap_start;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        c_data_d = c_data_q;
        avail_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.ap_start) begin
                state_d = LOAD;
                op_d    = op_e'(bus.op);
                beat_d  = '0;
            end
            LOAD: if (accept) begin
                beat_d = beat_q + 1'b1;
                if (last_beat) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: if (lat_q == '0) state_d = DONE; else lat_d = lat_q - 1'b1;
            DONE: if (bus.ap_continue) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Entering straight from LOAD the last beat is still in flight, so take the lane's next value.
        if (state_d == DONE && state_q != DONE) begin
            avail_d  = 1'b1;
            c_data_d = (state_q == WAIT) ? {a_acc, b_acc} : {a_nxt, b_nxt};
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_PASS;
            beat_q   <= '0;
            lat_q    <= '0;
            c_data_q <= '0;
            avail_q  <= 1'b0;
        end else if (bus.ap_ce) begin
            state_q  <= state_d;
            op_q     <= op_d;
            beat_q   <= beat_d;
            lat_q    <= lat_d;
            c_data_q <= c_data_d;
            avail_q  <= avail_d;
        end
    end

    tensor_slice_reduce #(.W(A_W)) u_lane_a (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .op      (op_q),
        .clear   (bus.ap_ce & start_take),
        .en      (bus.ap_ce & accept),
        .din     (bus.a_data),
        .acc     (a_acc),
        .acc_nxt (a_nxt)
    );

    tensor_slice_reduce #(.W(B_W)) u_lane_b (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .op      (op_q),
        .clear   (bus.ap_ce & start_take),
        .en      (bus.ap_ce & accept),
        .din     (bus.b_data),
        .acc     (b_acc),
        .acc_nxt (b_nxt)
    );

    // ap_ready is not gated by ap_ce so a frozen last-beat accept stays visible.
    assign bus.ap_idle               = (state_q == IDLE);
    assign bus.in_ready              = (state_q == LOAD);
    assign bus.ap_done               = (state_q == DONE);
    assign bus.ap_ready              = accept && last_beat;
    assign bus.c_data_out            = c_data_q;
    assign bus.c_data_available_port = avail_q;
endmodule

// File: tb/tb_tensor_slice_chain_wrapper.sv
// tb/tb_tensor_slice_chain_wrapper.sv - self-checking bench for tensor_slice_chain_wrapper
module tb_tensor_slice_chain_wrapper;
    import tensor_slice_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a_base;
        logic [63:0] a_step;
        logic [63:0] b_val;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b1, start = 1'b0, cont = 1'b0, valid = 1'b0;
    logic [1:0]  opv = 2'd0;
    logic [63:0] a_in = '0, b_in = '0;
    logic [63:0] va [8];
    logic [63:0] vb [8];
    vec_t        tbl [5];
    int          cyc = 0;
    int          sel = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          rel;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tensor_slice_chain_wrapper_if #(.A_W(64), .B_W(64)) if8 ();
    tensor_slice_chain_wrapper_if #(.A_W(64), .B_W(64)) if2 ();
    tensor_slice_chain_wrapper_if #(.A_W(64), .B_W(64)) if0 ();

    assign if8.ap_ce = ce; assign if8.ap_start = start; assign if8.ap_continue = cont; assign if8.op = opv;
    assign if8.in_valid = valid; assign if8.a_data = a_in; assign if8.b_data = b_in;
    assign if2.ap_ce = ce; assign if2.ap_start = start; assign if2.ap_continue = cont; assign if2.op = opv;
    assign if2.in_valid = valid; assign if2.a_data = a_in; assign if2.b_data = b_in;
    assign if0.ap_ce = ce; assign if0.ap_start = start; assign if0.ap_continue = cont; assign if0.op = opv;
    assign if0.in_valid = valid; assign if0.a_data = a_in; assign if0.b_data = b_in;

    tensor_slice_chain_wrapper #(.A_W(64), .B_W(64), .BEATS(8), .LATENCY(4)) dut8 (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(if8));
    tensor_slice_chain_wrapper #(.A_W(64), .B_W(64), .BEATS(2), .LATENCY(4)) dut2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(if2));
    tensor_slice_chain_wrapper #(.A_W(64), .B_W(64), .BEATS(8), .LATENCY(0)) dut0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .bus(if0));

    logic         m_idle, m_ready, m_done, m_in_ready, m_avail;
    logic [127:0] m_c;

    always_comb begin
        case (sel)
            1: {m_idle, m_ready, m_done, m_in_ready, m_avail, m_c} = {if2.ap_idle, if2.ap_ready,
                   if2.ap_done, if2.in_ready, if2.c_data_available_port, if2.c_data_out};
            2: {m_idle, m_ready, m_done, m_in_ready, m_avail, m_c} = {if0.ap_idle, if0.ap_ready,
                   if0.ap_done, if0.in_ready, if0.c_data_available_port, if0.c_data_out};
            default: {m_idle, m_ready, m_done, m_in_ready, m_avail, m_c} = {if8.ap_idle, if8.ap_ready,
                   if8.ap_done, if8.in_ready, if8.c_data_available_port, if8.c_data_out};
        endcase
    end

    function automatic int beats_of(int s);
        return (s == 1) ? 2 : 8;
    endfunction

    function automatic int lat_of(int s);
        return (s == 2) ? 0 : 4;
    endfunction

    function automatic logic [63:0] red(logic [1:0] o, logic [63:0] acc, logic [63:0] d);
        case (o)
            2'd0:    return d;
            2'd1:    return acc ^ d;
            2'd2:    return acc + d;
            default: return (d > acc) ? d : acc;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ce = 1'b1; start = 1'b0; cont = 1'b0; valid = 1'b0;
        opv = 2'd0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // mode 0: valid every cycle, 1: alternating, 2: random. stall_at freezes ap_ce for 3 cycles at that beat.
    task automatic run_txn(input logic [1:0] o, input int mode, input int stall_at,
                           input int hold, input bit chain, output int rel_o);
        int nb, lat, k, t0, stall_left;
        logic [63:0] ea, eb;
        logic v, c_e;
        nb = beats_of(sel); lat = lat_of(sel);
        ea = '0; eb = '0; k = 0; rel_o = -1;
        stall_left = (stall_at >= 0) ? 3 : 0;
        opv = o; start = 1'b1; cont = 1'b0; valid = 1'b0; ce = 1'b1;
        @(negedge clk);
        chk("idle_at_start", m_idle, 1);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 300 && k < nb; c++) begin
            c_e = !(k == stall_at && stall_left > 0);
            if (!c_e) stall_left--;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            ce = c_e; valid = v; a_in = va[k]; b_in = vb[k];
            @(negedge clk);
            chk("in_ready_load", m_in_ready, 1);
            chk("ap_ready_pulse", m_ready, v && (k == nb - 1));
            chk("no_early_done", m_done, 0);
            if (v && c_e) begin
                ea = red(o, ea, va[k]);
                eb = red(o, eb, vb[k]);
                k++;
            end
            @(posedge clk); #1;
        end
        chk("beats_accepted", k, nb);
        ce = 1'b1; valid = 1'b0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk("wait_no_done", m_done, 0);
            chk("wait_not_loading", m_in_ready, 0);
            @(posedge clk); #1;
        end
        for (int h = 0; h <= hold; h++) begin
            start = (h < hold) || chain;
            cont = (h == hold);
            @(negedge clk);
            if (h == 0) rel_o = cyc - t0;
            chk("done_high", m_done, 1);
            chk("avail_first_only", m_avail, h == 0);
            chk("result", m_c, {ea, eb});
            @(posedge clk); #1;
        end
        cont = 1'b0;
        @(negedge clk);
        chk("idle_after_continue", m_idle, 1);
        chk("done_released", m_done, 0);
        if (chain) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("chained_start_load", m_in_ready, 1);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_pattern(input logic [63:0] a_base, input logic [63:0] a_step, input logic [63:0] b_val);
        for (int i = 0; i < 8; i++) begin
            va[i] = a_base + 64'(i) * a_step;
            vb[i] = b_val;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd2, 64'd1, 64'd1, 64'hFF, 64'd36, 64'h7F8};
        tbl[1] = '{2'd1, 64'd1, 64'd1, 64'hFF, 64'd8, 64'd0};
        tbl[2] = '{2'd0, 64'd1, 64'd1, 64'hFF, 64'd8, 64'hFF};
        tbl[3] = '{2'd3, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h10, 64'd5};
        tbl[4] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd1, 64'h8000_0000_0000_0000,
                   64'hFFFF_FFFF_FFFF_FF9C, 64'd0};

        do_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("rst_idle", m_idle, 1);
            chk("rst_done", m_done, 0);
            chk("rst_ready", m_ready, 0);
            chk("rst_in_ready", m_in_ready, 0);
            chk("rst_avail", m_avail, 0);
            chk("rst_cdata", m_c, 0);
        end

        sel = 0;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_pattern(tbl[i].a_base, tbl[i].a_step, tbl[i].b_val);
            run_txn(tbl[i].op, 0, -1, 0, 1'b0, rel);
            chk("tbl_done_cycle", rel, 13);
            chk("tbl_result_held", m_c, {tbl[i].exp_a, tbl[i].exp_b});
        end

        sel = 1;
        do_reset();
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; va[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        vb[0] = 64'd1; vb[1] = 64'd1;
        run_txn(2'd2, 0, -1, 0, 1'b0, rel);
        chk("wrap_result", m_c, {64'hFFFF_FFFF_FFFF_FFFE, 64'd2});
        chk("beats2_done_cycle", rel, 7);

        sel = 0;
        do_reset();
        load_pattern(64'd1, 64'd1, 64'hFF);
        run_txn(2'd2, 1, -1, 0, 1'b0, rel);
        chk("toggle_done_cycle", rel, 20);
        run_txn(2'd2, 0, -1, 10, 1'b0, rel);
        chk("hold_result", m_c, {64'd36, 64'h7F8});

        opv = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in = va[i]; b_in = vb[i];
            @(posedge clk); #1;
        end
        valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("async_rst_idle", m_idle, 1);
        chk("async_rst_done", m_done, 0);
        chk("async_rst_in_ready", m_in_ready, 0);
        chk("async_rst_ready", m_ready, 0);
        chk("async_rst_avail", m_avail, 0);
        chk("async_rst_cdata", m_c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("aborted_no_done", m_done, 0);
        end
        @(posedge clk); #1;
        run_txn(2'd2, 0, -1, 0, 1'b0, rel);
        chk("after_rst_done_cycle", rel, 13);

        run_txn(2'd2, 0, 3, 0, 1'b0, rel);
        chk("ce_stall_done_cycle", rel, 16);
        chk("ce_stall_result", m_c, {64'd36, 64'h7F8});

        sel = 2;
        do_reset();
        run_txn(2'd2, 0, -1, 0, 1'b0, rel);
        chk("lat0_done_cycle", rel, 9);
        run_txn(2'd2, 0, 5, 1, 1'b0, rel);
        chk("lat0_stall_done_cycle", rel, 12);

        sel = 0;
        do_reset();
        run_txn(2'd1, 0, -1, 2, 1'b1, rel);

        for (int r = 0; r < 9; r++) begin
            sel = r % 3;
            do_reset();
            for (int i = 0; i < 8; i++) begin
                va[i] = {$urandom, $urandom};
                vb[i] = {$urandom, $urandom};
            end
            run_txn(2'($urandom_range(0, 3)), 2, -1, int'($urandom_range(0, 3)), 1'b0, rel);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
